decode_wb_pipe: RTL
===================

# decode_wb_pipe

Parametrised decode / write-back stage for the pipelined Y86 processor. It contains the architectural register file, the write-back port, source/destination selection, and the five-source forwarding network. It also contains the clocked D→E pipeline register with stall/bubble control. It replaces the purely combinational decode/write-back block: register width and register-ID width are generic, registers are cleared under reset, and forwarding is configurable.

## Interface
Parameters:
- XLEN, 64, data/register width in bits.
- RID_W, 4, register-ID width. RNONE = all-ones; registers 0..2^RID_W-2 exist.
- RSP_ID, 4, ID of the stack pointer.
- RSP_INIT, 0, reset value of register RSP_ID.

Ports:
- clk  in  1  clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- D_stat  in  3; D_icode, D_ifun  in  4; D_rA, D_rB  in  RID_W; D_valC, D_valP  in  XLEN — decode-stage register contents.
- e_dstE  in  RID_W; e_valE  in  XLEN — execute bypass.
- M_dstE, M_dstM  in  RID_W; M_valE, m_valM  in  XLEN — memory bypass.
- W_stat  in  3; W_icode  in  4; W_dstE, W_dstM  in  RID_W; W_valE, W_valM  in  XLEN — write-back.
- E_stall, E_bubble  in  1 — pipeline control for the E register.
- d_srcA, d_srcB, d_dstE, d_dstM  out  RID_W — combinational, for the hazard unit.
- E_stat  out  3; E_icode, E_ifun  out  4; E_valC, E_valA, E_valB  out  XLEN; E_dstE, E_dstM, E_srcA, E_srcB  out  RID_W — E register outputs.
- dbg_addr  in  RID_W; dbg_data  out  XLEN — combinational register-file peek. Reads 0 for RNONE.

## Operation
- **Source and destination selection by D_icode:**
  - d_srcA = D_rA for icodes 2, 4, 6, A; RSP_ID for 9, B; otherwise RNONE.
  - d_srcB = D_rB for 4, 5, 6; RSP_ID for 8, 9, A, B; otherwise RNONE.
  - d_dstE = D_rB for 2, 3, 6; RSP_ID for 8, 9, A, B; otherwise RNONE.
  - d_dstM = D_rA for 5, B; otherwise RNONE.
- **d_valA priority (first match wins):**
  1. icode 7 or 8 → D_valP
  2. d_srcA == e_dstE → e_valE
  3. == M_dstM → m_valM
  4. == M_dstE → M_valE
  5. == W_dstM → W_valM
  6. == W_dstE → W_valE
  7. otherwise regfile[d_srcA]
- **d_valB:** same chain without the valP step.
- **Forwarding matches:** a source of RNONE never matches, and always yields 0.
- **Write-back:**
  - At the rising edge, regfile[W_dstE] ← W_valE and regfile[W_dstM] ← W_valM, each only when its ID ≠ RNONE and W_stat == 3'b001 (AOK).
  - If W_dstE == W_dstM, W_valM wins.
- **E register, at the rising edge:**
  - E_bubble=1 → load a bubble: stat 001, icode 1 (NOP), ifun 0, values 0, all IDs RNONE.
  - E_bubble=0 and E_stall=1 → hold.
  - Both 0 → load the decode results; D_stat, D_icode, D_ifun and D_valC pass through.
  - Bubble has priority over stall.

## Timing
- Decode is combinational in the D cycle. Results appear on the E_* outputs one cycle later, after the next rising edge.
- A W write and a decode read of the same register in the same cycle: the new value reaches E through the W bypass. The register file itself updates at the edge.
- **Reset (asynchronous, any time including mid-operation):**
  - All registers are 0 except RSP_ID, which is RSP_INIT.
  - E register is set to the bubble values.
  - Release is synchronous to clk. There is no write on the edge where rst_n is low.
- Combinational outputs depend only on current inputs and register-file state.

## Configuration
- **DECODE_FWD_EN defined:** the full forwarding chain above is built.
- **DECODE_FWD_EN undefined:**
  - The e, M and W bypass steps are removed. d_valA/d_valB come from regfile (valA still takes valP for icodes 7 and 8).
  - The hazard unit must stall until write-back.
  - The e_*, M_* and m_* inputs are ignored.

## Test plan
- Reset with RSP_INIT=100, then release → dbg_addr=4 reads 100, every other register reads 0; E_icode=1, E_dstE=F.
- W_stat=001, W_dstE=7, W_valE=67; W_dstM=6, W_valM=43; one edge → regfile[7]=67, regfile[6]=43. Repeat with W_stat=011 → no change.
- D_icode=4, rA=6, rB=7, no bypass matches → next edge E_valA=43, E_valB=67. Then e_dstE=6, e_valE=404 → E_valA=404.
- Priority: M_dstM=M_dstE=W_dstE=2 with 11/33/67, D_icode=6, rA=2 → E_valA=11. Under no-macro build → regfile value.
- E_stall=1 while D changes → E holds. E_bubble=1 together with E_stall=1 → NOP bubble.
- W_dstE=W_dstM=4 (valE=8, valM=9) → regfile[4]=9. Reset pulse mid-stream → E bubble and registers cleared immediately.

Source files
------------

// File: rtl/decode_wb_pipe.sv
// Y86 decode / write-back stage: register file, source/destination selection,
// forwarding network and the D->E pipeline register. Optional macro: DECODE_FWD_EN.
module decode_wb_pipe #(
  parameter int              XLEN     = 64,
  parameter int              RID_W    = 4,
  parameter int              RSP_ID   = 4,
  parameter logic [XLEN-1:0] RSP_INIT = {XLEN{1'b0}}
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [2:0]       D_stat,
  input  logic [3:0]       D_icode,
  input  logic [3:0]       D_ifun,
  input  logic [RID_W-1:0] D_rA,
  input  logic [RID_W-1:0] D_rB,
  input  logic [XLEN-1:0]  D_valC,
  input  logic [XLEN-1:0]  D_valP,
  input  logic [RID_W-1:0] e_dstE,
  input  logic [XLEN-1:0]  e_valE,
  input  logic [RID_W-1:0] M_dstE,
  input  logic [RID_W-1:0] M_dstM,
  input  logic [XLEN-1:0]  M_valE,
  input  logic [XLEN-1:0]  m_valM,
  input  logic [2:0]       W_stat,
  input  logic [3:0]       W_icode,
  input  logic [RID_W-1:0] W_dstE,
  input  logic [RID_W-1:0] W_dstM,
  input  logic [XLEN-1:0]  W_valE,
  input  logic [XLEN-1:0]  W_valM,
  input  logic             E_stall,
  input  logic             E_bubble,
  output logic [RID_W-1:0] d_srcA,
  output logic [RID_W-1:0] d_srcB,
  output logic [RID_W-1:0] d_dstE,
  output logic [RID_W-1:0] d_dstM,
  output logic [2:0]       E_stat,
  output logic [3:0]       E_icode,
  output logic [3:0]       E_ifun,
  output logic [XLEN-1:0]  E_valC,
  output logic [XLEN-1:0]  E_valA,
  output logic [XLEN-1:0]  E_valB,
  output logic [RID_W-1:0] E_dstE,
  output logic [RID_W-1:0] E_dstM,
  output logic [RID_W-1:0] E_srcA,
  output logic [RID_W-1:0] E_srcB,
  input  logic [RID_W-1:0] dbg_addr,
  output logic [XLEN-1:0]  dbg_data
);

  localparam logic [RID_W-1:0] RNONE = {RID_W{1'b1}};
  localparam logic [RID_W-1:0] RSP   = RSP_ID[RID_W-1:0];
  localparam int               NREG  = (1 << RID_W) - 1;
  localparam logic [2:0]       S_AOK = 3'b001;
  localparam logic [3:0]       I_NOP = 4'h1;

  typedef struct packed {
    logic [2:0]       stat;
    logic [3:0]       icode;
    logic [3:0]       ifun;
    logic [XLEN-1:0]  valC;
    logic [XLEN-1:0]  valA;
    logic [XLEN-1:0]  valB;
    logic [RID_W-1:0] dstE;
    logic [RID_W-1:0] dstM;
    logic [RID_W-1:0] srcA;
    logic [RID_W-1:0] srcB;
  } e_reg_t;

  localparam e_reg_t E_BUBBLE = '{
    stat: S_AOK, icode: I_NOP, ifun: 4'h0,
    valC: {XLEN{1'b0}}, valA: {XLEN{1'b0}}, valB: {XLEN{1'b0}},
    dstE: RNONE, dstM: RNONE, srcA: RNONE, srcB: RNONE
  };

  logic [XLEN-1:0] rf_q [NREG];
  logic [XLEN-1:0] rf_d [NREG];
  e_reg_t          e_q;
  e_reg_t          e_d;
  logic [XLEN-1:0] d_valA;
  logic [XLEN-1:0] d_valB;
  logic            wr_e_s;
  logic            wr_m_s;
  logic            unused_s;

`ifdef DECODE_FWD_EN
  assign unused_s = ^{W_icode};
`else
  assign unused_s = ^{W_icode, e_dstE, e_valE, M_dstE, M_dstM, M_valE, m_valM};
`endif

  // Operand value for a source ID; RNONE always yields zero.
  function automatic logic [XLEN-1:0] src_val(input logic [RID_W-1:0] src);
    logic [XLEN-1:0] v;
    if (src == RNONE) v = {XLEN{1'b0}};
`ifdef DECODE_FWD_EN
    else if (src == e_dstE) v = e_valE;
    else if (src == M_dstM) v = m_valM;
    else if (src == M_dstE) v = M_valE;
    else if (src == W_dstM) v = W_valM;
    else if (src == W_dstE) v = W_valE;
`endif
    else v = rf_q[src];
    return v;
  endfunction

  always_comb begin
    d_srcA = RNONE;
    d_srcB = RNONE;
    d_dstE = RNONE;
    d_dstM = RNONE;
    case (D_icode)
      4'h2, 4'h4, 4'h6, 4'hA: d_srcA = D_rA;
      4'h9, 4'hB:             d_srcA = RSP;
      default:                d_srcA = RNONE;
    endcase
    case (D_icode)
      4'h4, 4'h5, 4'h6:       d_srcB = D_rB;
      4'h8, 4'h9, 4'hA, 4'hB: d_srcB = RSP;
      default:                d_srcB = RNONE;
    endcase
    case (D_icode)
      4'h2, 4'h3, 4'h6:       d_dstE = D_rB;
      4'h8, 4'h9, 4'hA, 4'hB: d_dstE = RSP;
      default:                d_dstE = RNONE;
    endcase
    case (D_icode)
      4'h5, 4'hB: d_dstM = D_rA;
      default:    d_dstM = RNONE;
    endcase
  end

  always_comb begin
    d_valA = {XLEN{1'b0}};
    if (D_icode == 4'h7 || D_icode == 4'h8) d_valA = D_valP;
    else d_valA = src_val(d_srcA);
    d_valB = src_val(d_srcB);
  end

  always_comb begin
    dbg_data = {XLEN{1'b0}};
    if (dbg_addr == RNONE) dbg_data = {XLEN{1'b0}};
    else dbg_data = rf_q[dbg_addr];
  end

  // Write-back: the M port has priority when both ports name the same register.
  assign wr_e_s = (W_stat == S_AOK) && (W_dstE != RNONE);
  assign wr_m_s = (W_stat == S_AOK) && (W_dstM != RNONE);

  always_comb begin
    for (int i = 0; i < NREG; i++) begin
      if (wr_m_s && W_dstM == RID_W'(i)) rf_d[i] = W_valM;
      else if (wr_e_s && W_dstE == RID_W'(i)) rf_d[i] = W_valE;
      else rf_d[i] = rf_q[i];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NREG; i++) rf_q[i] <= (i == RSP_ID) ? RSP_INIT : {XLEN{1'b0}};
    end else begin
      for (int i = 0; i < NREG; i++) rf_q[i] <= rf_d[i];
    end
  end

  // E register next state: bubble beats stall.
  always_comb begin
    e_d = e_q;
    if (E_bubble) begin
      e_d = E_BUBBLE;
    end else if (E_stall) begin
      e_d = e_q;
    end else begin
      e_d.stat  = D_stat;
      e_d.icode = D_icode;
      e_d.ifun  = D_ifun;
      e_d.valC  = D_valC;
      e_d.valA  = d_valA;
      e_d.valB  = d_valB;
      e_d.dstE  = d_dstE;
      e_d.dstM  = d_dstM;
      e_d.srcA  = d_srcA;
      e_d.srcB  = d_srcB;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) e_q <= E_BUBBLE;
    else        e_q <= e_d;
  end

  assign E_stat  = e_q.stat;
  assign E_icode = e_q.icode;
  assign E_ifun  = e_q.ifun;
  assign E_valC  = e_q.valC;
  assign E_valA  = e_q.valA;
  assign E_valB  = e_q.valB;
  assign E_dstE  = e_q.dstE;
  assign E_dstM  = e_q.dstM;
  assign E_srcA  = e_q.srcA;
  assign E_srcB  = e_q.srcB;

endmodule
